// File: rtl/user_session_pkg.sv
// user_session_pkg: shared types, the guest ID, the fixed per-user key table
// and the key-match helper used by the session/authentication stage.
package user_session_pkg;

  typedef logic [2:0] user_id_t;
  typedef logic [7:0] user_key_t;
  typedef logic [7:0] user_data_t;

  localparam user_id_t GUEST_ID = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_SESSION = 2'd2,
    ST_LOCKED  = 2'd3
  } session_state_t;

  localparam user_key_t KEY_TABLE [0:7] = '{
    8'h00, 8'h3C, 8'h7E, 8'h96, 8'h5A, 8'hA5, 8'hC3, 8'hF0
  };

  // The guest identity can never authenticate, whatever key is presented.
  function automatic logic key_ok(input user_id_t id, input user_key_t key);
    return (id != GUEST_ID) && (key == KEY_TABLE[id]);
  endfunction

endpackage

// File: rtl/user_session_if.sv
// user_session_if: login, write and grant-side signals of the session stage.
// master = the requester side (drives logins/writes), slave = the auth block.
interface user_session_if;
  import user_session_pkg::*;

  logic       login_valid;
  user_id_t   login_id;
  user_key_t  login_key;
  logic       logout;
  logic       wr_valid;
  user_data_t wr_data;

  user_id_t   usr_id;
  user_data_t grant_data;
  logic       grant_valid;
  logic       session_active;
  logic       login_fail;
  logic       locked;

  modport master (
    output login_valid, login_id, login_key, logout, wr_valid, wr_data,
    input  usr_id, grant_data, grant_valid, session_active, login_fail, locked
  );

  modport slave (
    input  login_valid, login_id, login_key, logout, wr_valid, wr_data,
    output usr_id, grant_data, grant_valid, session_active, login_fail, locked
  );

endinterface

// File: rtl/user_session_auth_lockout_ctr.sv
// auth_lockout_ctr: consecutive-failure counter and lockout timer.
// lock_start fires combinationally on the failure that reaches MAX_FAIL so the
// controller can enter LOCKED on the same edge. lock_active stays high while
// the lockout still has more than the current cycle left to run.
module auth_lockout_ctr
  import user_session_pkg::*;
#(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fail,
  input  logic clear,
  output logic lock_start,
  output logic lock_active
);

  localparam logic [3:0] MAX_FAIL_C = 4'(MAX_FAIL);
  localparam logic [7:0] LOCK_C     = 8'(LOCK_CYCLES);

  logic [3:0] fail_cnt;
  logic [3:0] fail_cnt_inc;
  logic [7:0] timer;

  // Saturating increment: the count parks at MAX_FAIL instead of wrapping.
  always_comb begin
    fail_cnt_inc = fail_cnt;
    if (fail_cnt != MAX_FAIL_C) fail_cnt_inc = fail_cnt + 4'd1;
  end

  assign lock_start  = fail && (fail_cnt_inc == MAX_FAIL_C);
  assign lock_active = (timer > 8'd1);

  // Failure count: cleared on success or lockout expiry, bumped on each reject.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     fail_cnt <= '0;
    else if (clear) fail_cnt <= '0;
    else if (fail)  fail_cnt <= fail_cnt_inc;
  end

  // Lock timer: loaded on lockout entry, then counts down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              timer <= '0;
    else if (lock_start)     timer <= LOCK_C;
    else if (timer != 8'd0)  timer <= timer - 8'd1;
  end

endmodule

// File: rtl/user_session_auth.sv
// user_session_auth: login check against the fixed key table, session hold,
// and forwarding of the session owner's writes to the grant-access stage.
// Optional feature macro: USER_SESSION_LOCKOUT_EN (lockout after MAX_FAIL
// consecutive rejected logins, lasting LOCK_CYCLES cycles).
module user_session_auth
  import user_session_pkg::*;
#(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  user_session_if.slave bus
);

  if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_bad_max_fail
    $error("user_session_auth: MAX_FAIL must be in 1..15");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_lock_cycles
    $error("user_session_auth: LOCK_CYCLES must be in 1..255");
  end

  session_state_t state_q, state_d;

  user_id_t   login_id_p0;
  user_key_t  login_key_p0;

  user_id_t   usr_id_q;
  user_data_t grant_data_q;
  logic       grant_valid_q;
  logic       session_active_q;
  logic       login_fail_q;
  logic       locked_q;

  logic       key_match;
  logic       check_pass;
  logic       check_fail;
  logic       in_session;

  assign key_match  = key_ok(login_id_p0, login_key_p0);
  assign check_pass = (state_q == ST_CHECK) &&  key_match;
  assign check_fail = (state_q == ST_CHECK) && !key_match;
  assign in_session = (state_q == ST_SESSION);

`ifdef USER_SESSION_LOCKOUT_EN
  logic lock_start;
  logic lock_active;
  logic lock_expire;

  assign lock_expire = (state_q == ST_LOCKED) && !lock_active;

  auth_lockout_ctr #(
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout (
    .clk         (clk),
    .rst_n       (rst_n),
    .fail        (check_fail),
    .clear       (check_pass || lock_expire),
    .lock_start  (lock_start),
    .lock_active (lock_active)
  );

  // locked mirrors the LOCKED state as a registered flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) locked_q <= 1'b0;
    else        locked_q <= (state_d == ST_LOCKED);
  end
`else
  localparam logic [3:0] MAX_FAIL_C = 4'(MAX_FAIL);
  logic [3:0] fail_cnt;

  // Failure count kept for bookkeeping only; without lockout it never gates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fail_cnt <= '0;
    else if (check_pass)
      fail_cnt <= '0;
    else if (check_fail && (fail_cnt != MAX_FAIL_C))
      fail_cnt <= fail_cnt + 4'd1;
  end

  assign locked_q = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; CHECK always resolves in one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.login_valid) state_d = ST_CHECK;
      ST_CHECK: begin
        if (key_match) begin
          state_d = ST_SESSION;
        end else begin
          state_d = ST_IDLE;
`ifdef USER_SESSION_LOCKOUT_EN
          if (lock_start) state_d = ST_LOCKED;
`endif
        end
      end
      ST_SESSION: if (bus.logout) state_d = ST_IDLE;
`ifdef USER_SESSION_LOCKOUT_EN
      ST_LOCKED:  if (!lock_active) state_d = ST_IDLE;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---- stage p0: capture the login attempt for the CHECK cycle ----
  // Attempt capture; only IDLE accepts a login strobe.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && bus.login_valid) begin
      login_id_p0  <= bus.login_id;
      login_key_p0 <= bus.login_key;
    end
  end

  // ---- stage p1: registered outputs toward the grant stage ----
  // Output registers; logout beats a same-cycle write and clears the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usr_id_q         <= GUEST_ID;
      grant_data_q     <= '0;
      grant_valid_q    <= 1'b0;
      session_active_q <= 1'b0;
      login_fail_q     <= 1'b0;
    end else begin
      grant_valid_q    <= in_session && bus.wr_valid && !bus.logout;
      session_active_q <= (state_d == ST_SESSION);
      login_fail_q     <= check_fail;

      if (check_pass)                  usr_id_q <= login_id_p0;
      else if (state_d != ST_SESSION)  usr_id_q <= GUEST_ID;

      if (in_session && bus.logout)        grant_data_q <= '0;
      else if (in_session && bus.wr_valid) grant_data_q <= bus.wr_data;
    end
  end

  assign bus.usr_id         = usr_id_q;
  assign bus.grant_data     = grant_data_q;
  assign bus.grant_valid    = grant_valid_q;
  assign bus.session_active = session_active_q;
  assign bus.login_fail     = login_fail_q;
  assign bus.locked         = locked_q;

endmodule

// File: tb/tb_user_session_auth.sv
// tb_user_session_auth: directed vectors for user_session_auth with
// hand-computed expectations. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_user_session_auth;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  user_session_if bus();

  user_session_auth #(
    .MAX_FAIL    (3),
    .LOCK_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one login, then wait for the decision edge.
  task automatic login(input logic [2:0] id, input logic [7:0] key);
    bus.login_valid = 1'b1;
    bus.login_id    = id;
    bus.login_key   = key;
    @(negedge clk);
    bus.login_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_logout();
    bus.logout = 1'b1;
    @(negedge clk);
    bus.logout = 1'b0;
  endtask

  initial begin
    int n;
    bus.login_valid = 1'b0;
    bus.login_id    = '0;
    bus.login_key   = '0;
    bus.logout      = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = '0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_usr_id", bus.usr_id, 0);
    chk("rst_grant_data", bus.grant_data, 0);
    chk("rst_grant_valid", bus.grant_valid, 0);
    chk("rst_session", bus.session_active, 0);
    chk("rst_login_fail", bus.login_fail, 0);
    chk("rst_locked", bus.locked, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Valid login and write
    login(3'd5, 8'hA5);
    chk("ok_session", bus.session_active, 1);
    chk("ok_usr_id", bus.usr_id, 5);
    chk("ok_no_fail", bus.login_fail, 0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h11;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk("wr_data", bus.grant_data, 8'h11);
    chk("wr_valid", bus.grant_valid, 1);
    @(negedge clk);
    chk("wr_pulse_end", bus.grant_valid, 0);
    chk("wr_data_hold", bus.grant_data, 8'h11);
    do_logout();
    chk("lo_session", bus.session_active, 0);
    chk("lo_usr_id", bus.usr_id, 0);
    chk("lo_data_clr", bus.grant_data, 0);

    // Bad key, then correct key
    login(3'd4, 8'h01);
    chk("bad_fail", bus.login_fail, 1);
    chk("bad_usr_id", bus.usr_id, 0);
    chk("bad_session", bus.session_active, 0);
    @(negedge clk);
    chk("bad_fail_pulse", bus.login_fail, 0);
    login(3'd4, 8'h5A);
    chk("retry_session", bus.session_active, 1);
    chk("retry_usr_id", bus.usr_id, 4);
    do_logout();

    // Guest login always rejected
    login(3'd0, 8'h00);
    chk("guest_fail", bus.login_fail, 1);
    chk("guest_session", bus.session_active, 0);
    chk("guest_usr_id", bus.usr_id, 0);

    // Logout and write collide (success also clears the failure count)
    login(3'd5, 8'hA5);
    chk("col_session", bus.session_active, 1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h33;
    @(negedge clk);
    chk("col_pre_data", bus.grant_data, 8'h33);
    bus.wr_data  = 8'h22;
    bus.logout   = 1'b1;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.logout   = 1'b0;
    chk("col_no_valid", bus.grant_valid, 0);
    chk("col_data_clr", bus.grant_data, 0);
    chk("col_usr_id", bus.usr_id, 0);
    chk("col_session_off", bus.session_active, 0);

    // Three consecutive failures
    login(3'd1, 8'h00);
    chk("lk_fail1", bus.login_fail, 1);
    chk("lk_locked1", bus.locked, 0);
    login(3'd2, 8'h00);
    chk("lk_fail2", bus.login_fail, 1);
    chk("lk_locked2", bus.locked, 0);
    login(3'd3, 8'h00);
    chk("lk_fail3", bus.login_fail, 1);
`ifdef USER_SESSION_LOCKOUT_EN
    chk("lk_locked3", bus.locked, 1);
    // A correct login held throughout the lock must be ignored.
    bus.login_valid = 1'b1;
    bus.login_id    = 3'd5;
    bus.login_key   = 8'hA5;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.locked) n++;
      else break;
    end
    bus.login_valid = 1'b0;
    chk("lk_duration", n, 16);
    chk("lk_ignored", bus.session_active, 0);
    chk("lk_unlocked", bus.locked, 0);
    login(3'd5, 8'hA5);
    chk("lk_after_session", bus.session_active, 1);
    chk("lk_after_usr_id", bus.usr_id, 5);
`else
    chk("nolk_locked", bus.locked, 0);
    login(3'd5, 8'hA5);
    chk("nolk_session", bus.session_active, 1);
    chk("nolk_usr_id", bus.usr_id, 5);
`endif

    // Asynchronous reset in the middle of a session
    #2 rst_n = 1'b0;
    #1;
    chk("arst_usr_id", bus.usr_id, 0);
    chk("arst_session", bus.session_active, 0);
    chk("arst_locked", bus.locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_session", bus.session_active, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
